// File: rtl/dcpu16_arb.sv
// Two-port arbiter that shares one memory port between FBUS (fetch/save) and GBUS (operand load).
// It registers the memory request on grant, passes the memory response through, and a watchdog ends cycles the memory never acknowledges.
module dcpu16_arb #(
    parameter bit RRB = 1'b1,
    parameter int TMO = 16,
    parameter int CW  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] f_adr,
    input  logic [15:0] f_dto,
    input  logic        f_stb,
    input  logic        f_wre,
    output logic [15:0] f_dti,
    output logic        f_ack,
    input  logic [15:0] g_adr,
    input  logic [15:0] g_dto,
    input  logic        g_stb,
    input  logic        g_wre,
    output logic [15:0] g_dti,
    output logic        g_ack,
    output logic [15:0] m_adr,
    output logic [15:0] m_dto,
    output logic        m_stb,
    output logic        m_wre,
    input  logic [15:0] m_dti,
    input  logic        m_ack,
    output logic [1:0]  gnt,
    output logic        tmo
);

    // state | meaning
    // IDLE  | no transfer; one turnaround cycle follows every transfer
    // BUSF  | memory cycle owned by FBUS
    // BUSG  | memory cycle owned by GBUS
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSF = 2'd1,
        BUSG = 2'd2
    } state_t;

    localparam bit            WD_EN   = (TMO > 0);
    localparam logic [CW-1:0] WD_LAST = CW'((TMO > 0) ? (TMO - 1) : 0);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wdc;
    logic          lst;
    logic          grant_f;
    logic          grant_g;
    logic          own_stb;
    logic          wd_hit;
    logic          leave;

    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_g   = 1'b0;
        own_stb   = 1'b0;
        wd_hit    = 1'b0;
        leave     = 1'b0;
        f_ack     = 1'b0;
        g_ack     = 1'b0;
        f_dti     = 16'h0000;
        g_dti     = 16'h0000;
        case (state)
            IDLE: begin
                // lst set means GBUS was served last, so a tie goes to FBUS
                if (f_stb && (!g_stb || !RRB || lst)) begin
                    grant_f   = 1'b1;
                    state_nxt = BUSF;
                end else if (g_stb) begin
                    grant_g   = 1'b1;
                    state_nxt = BUSG;
                end
            end
            BUSF, BUSG: begin
                own_stb = (state == BUSF) ? f_stb : g_stb;
                // an abort takes precedence over expiry: a withdrawn request gets no ack
                wd_hit  = WD_EN && (wdc == WD_LAST) && !m_ack && own_stb;
                leave   = m_ack || !own_stb || wd_hit;
                if (leave) begin
                    state_nxt = IDLE;
                end
                if (state == BUSF) begin
                    f_ack = m_ack || wd_hit;
                    f_dti = wd_hit ? 16'hFFFF : m_dti;
                end else begin
                    g_ack = m_ack || wd_hit;
                    g_dti = wd_hit ? 16'hFFFF : m_dti;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            m_adr <= 16'h0000;
            m_dto <= 16'h0000;
            m_stb <= 1'b0;
            m_wre <= 1'b0;
            gnt   <= 2'b00;
            tmo   <= 1'b0;
            wdc   <= '0;
            lst   <= 1'b1;
        end else begin
            state <= state_nxt;
            tmo   <= wd_hit;
            if (grant_f || grant_g) begin
                m_adr <= grant_f ? f_adr : g_adr;
                m_dto <= grant_f ? f_dto : g_dto;
                m_wre <= grant_f ? f_wre : g_wre;
                m_stb <= 1'b1;
                gnt   <= {grant_g, grant_f};
                lst   <= grant_g;
                wdc   <= '0;
            end else if (leave) begin
                m_stb <= 1'b0;
                m_wre <= 1'b0;
                gnt   <= 2'b00;
            end else if (state != IDLE) begin
                wdc <= wdc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcpu16_arb.sv
// Randomized bench for dcpu16_arb: a round-robin instance with a short watchdog and a fixed-priority instance without a watchdog.
// Both instances share the request buses and are compared every cycle against a transfer-level reference model.
module tb_dcpu16_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] f_adr, f_dto, g_adr, g_dto;
    logic        f_stb, f_wre, g_stb, g_wre;

    logic [15:0] m_dti_i [2];
    logic        m_ack_i [2];
    logic [15:0] f_dti_o [2];
    logic [15:0] g_dti_o [2];
    logic [15:0] m_adr_o [2];
    logic [15:0] m_dto_o [2];
    logic        f_ack_o [2];
    logic        g_ack_o [2];
    logic        m_stb_o [2];
    logic        m_wre_o [2];
    logic        tmo_o   [2];
    logic [1:0]  gnt_o   [2];

    always #5 clk = ~clk;

    dcpu16_arb #(.RRB(1'b1), .TMO(4), .CW(3)) u_rr (
        .clk(clk), .rst(rst),
        .f_adr(f_adr), .f_dto(f_dto), .f_stb(f_stb), .f_wre(f_wre),
        .f_dti(f_dti_o[0]), .f_ack(f_ack_o[0]),
        .g_adr(g_adr), .g_dto(g_dto), .g_stb(g_stb), .g_wre(g_wre),
        .g_dti(g_dti_o[0]), .g_ack(g_ack_o[0]),
        .m_adr(m_adr_o[0]), .m_dto(m_dto_o[0]), .m_stb(m_stb_o[0]), .m_wre(m_wre_o[0]),
        .m_dti(m_dti_i[0]), .m_ack(m_ack_i[0]),
        .gnt(gnt_o[0]), .tmo(tmo_o[0])
    );

    dcpu16_arb #(.RRB(1'b0), .TMO(0), .CW(5)) u_fp (
        .clk(clk), .rst(rst),
        .f_adr(f_adr), .f_dto(f_dto), .f_stb(f_stb), .f_wre(f_wre),
        .f_dti(f_dti_o[1]), .f_ack(f_ack_o[1]),
        .g_adr(g_adr), .g_dto(g_dto), .g_stb(g_stb), .g_wre(g_wre),
        .g_dti(g_dti_o[1]), .g_ack(g_ack_o[1]),
        .m_adr(m_adr_o[1]), .m_dto(m_dto_o[1]), .m_stb(m_stb_o[1]), .m_wre(m_wre_o[1]),
        .m_dti(m_dti_i[1]), .m_ack(m_ack_i[1]),
        .gnt(gnt_o[1]), .tmo(tmo_o[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the memory (0 none, 1 FBUS, 2 GBUS) and how long it has waited.
    int          owner   [2];
    int          waited  [2];
    bit          last_g  [2];
    logic [15:0] cap_adr [2];
    logic [15:0] cap_dto [2];
    bit          cap_wre [2];
    bit          tmo_exp [2];

    function automatic int limit_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic bit rr_of(input int d);
        return (d == 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d]   = 0;
            waited[d]  = 0;
            last_g[d]  = 1'b1;
            cap_adr[d] = 16'h0000;
            cap_dto[d] = 16'h0000;
            cap_wre[d] = 1'b0;
            tmo_exp[d] = 1'b0;
        end
    endtask

    task automatic check_and_step(input int d);
        bit          req;
        bit          fire;
        bit          ack;
        logic [15:0] rd;
        int          win;
        string       s;
        s    = $sformatf("[%0d]", d);
        req  = (owner[d] == 1) ? f_stb : (owner[d] == 2) ? g_stb : 1'b0;
        fire = (limit_of(d) > 0) && (owner[d] != 0) && (waited[d] == limit_of(d) - 1)
               && !m_ack_i[d] && req;
        ack  = (owner[d] != 0) && (m_ack_i[d] || fire);
        rd   = fire ? 16'hFFFF : m_dti_i[d];

        chk({"m_stb", s}, m_stb_o[d], owner[d] != 0);
        chk({"gnt", s}, gnt_o[d], (owner[d] == 1) ? 2'b01 : (owner[d] == 2) ? 2'b10 : 2'b00);
        chk({"m_adr", s}, m_adr_o[d], cap_adr[d]);
        chk({"m_dto", s}, m_dto_o[d], cap_dto[d]);
        chk({"m_wre", s}, m_wre_o[d], (owner[d] != 0) && cap_wre[d]);
        chk({"tmo", s}, tmo_o[d], tmo_exp[d]);
        chk({"f_ack", s}, f_ack_o[d], (owner[d] == 1) && ack);
        chk({"g_ack", s}, g_ack_o[d], (owner[d] == 2) && ack);
        if (owner[d] == 1) begin
            chk({"f_dti", s}, f_dti_o[d], rd);
            chk({"g_dti_idle_port", s}, g_dti_o[d], 16'h0000);
        end else if (owner[d] == 2) begin
            chk({"g_dti", s}, g_dti_o[d], rd);
            chk({"f_dti_idle_port", s}, f_dti_o[d], 16'h0000);
        end

        if (owner[d] == 0) begin
            tmo_exp[d] = 1'b0;
            win = 0;
            if (f_stb && g_stb) win = (rr_of(d) && !last_g[d]) ? 2 : 1;
            else if (f_stb)     win = 1;
            else if (g_stb)     win = 2;
            if (win != 0) begin
                owner[d]   = win;
                waited[d]  = 0;
                last_g[d]  = (win == 2);
                cap_adr[d] = (win == 1) ? f_adr : g_adr;
                cap_dto[d] = (win == 1) ? f_dto : g_dto;
                cap_wre[d] = (win == 1) ? f_wre : g_wre;
            end
        end else begin
            tmo_exp[d] = fire;
            if (m_ack_i[d] || !req || fire) owner[d] = 0;
            else waited[d]++;
        end
    endtask

    task automatic drive_random(input int ack_pct, input int flip_pct);
        if ($urandom_range(0, 99) < flip_pct) f_stb = ~f_stb;
        if ($urandom_range(0, 99) < flip_pct) g_stb = ~g_stb;
        f_adr = 16'($urandom);
        f_dto = 16'($urandom);
        f_wre = 1'($urandom);
        g_adr = 16'($urandom);
        g_dto = 16'($urandom);
        g_wre = 1'($urandom);
        for (int d = 0; d < 2; d++) begin
            m_ack_i[d] = ($urandom_range(0, 99) < ack_pct);
            m_dti_i[d] = 16'($urandom);
        end
    endtask

    task automatic clear_inputs();
        f_adr = 16'h0; f_dto = 16'h0; f_stb = 1'b0; f_wre = 1'b0;
        g_adr = 16'h0; g_dto = 16'h0; g_stb = 1'b0; g_wre = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_ack_i[d] = 1'b0;
            m_dti_i[d] = 16'h0;
        end
    endtask

    task automatic run_phase(input int cycles, input int ack_pct, input int flip_pct);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            drive_random(ack_pct, flip_pct);
            #1;
            for (int d = 0; d < 2; d++) check_and_step(d);
        end
    endtask

    int ack_tbl  [6] = '{100, 40, 0, 10, 100, 60};
    int flip_tbl [6] = '{20, 15, 10, 25, 0, 30};

    initial begin
        clear_inputs();
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_m_stb[%0d]", d), m_stb_o[d], 1'b0);
            chk($sformatf("rst_gnt[%0d]", d), gnt_o[d], 2'b00);
            chk($sformatf("rst_tmo[%0d]", d), tmo_o[d], 1'b0);
            chk($sformatf("rst_m_adr[%0d]", d), m_adr_o[d], 16'h0000);
            chk($sformatf("rst_m_wre[%0d]", d), m_wre_o[d], 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;

        // first tie after reset must go to FBUS on both instances
        @(negedge clk);
        drive_random(0, 0);
        f_stb = 1'b1;
        g_stb = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check_and_step(d);

        for (int p = 0; p < 6; p++) run_phase(350, ack_tbl[p], flip_tbl[p]);

        // asynchronous reset in the middle of an FBUS transfer
        @(negedge clk);
        clear_inputs();
        #1;
        for (int d = 0; d < 2; d++) check_and_step(d);
        run_phase(3, 100, 0);
        @(negedge clk);
        clear_inputs();
        f_stb = 1'b1;
        f_adr = 16'h0100;
        #1;
        for (int d = 0; d < 2; d++) check_and_step(d);
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) chk($sformatf("pre_rst_m_stb[%0d]", d), m_stb_o[d], 1'b1);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("async_m_stb[%0d]", d), m_stb_o[d], 1'b0);
            chk($sformatf("async_gnt[%0d]", d), gnt_o[d], 2'b00);
            chk($sformatf("async_tmo[%0d]", d), tmo_o[d], 1'b0);
        end
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;

        for (int p = 0; p < 6; p++) run_phase(100, ack_tbl[p], flip_tbl[p]);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcpu16_arb.md
Name: dcpu16_arb

Overview:
Two-port bus arbiter that shares one external memory port between the CPU fetch/save bus (FBUS) and the operand-load bus (GBUS). It sits between the CPU top-level f_*/g_* ports and a single-ported memory. Requests are granted by fixed priority or round-robin, each memory cycle is forwarded with registered address and control, and a watchdog completes any cycle the memory never acknowledges.

Parameters:
RRB, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority with FBUS winning.
TMO, 16, watchdog limit in cycles spent in a BUS state without m_ack; 0 disables the watchdog.
CW, 5, watchdog counter width; must satisfy 2^CW > TMO.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
f_adr  in  16  FBUS address
f_dto  in  16  FBUS write data
f_stb  in  1  FBUS strobe/request
f_wre  in  1  FBUS write enable
f_dti  out  16  FBUS read data
f_ack  out  1  FBUS acknowledge
g_adr  in  16  GBUS address
g_dto  in  16  GBUS write data
g_stb  in  1  GBUS strobe/request
g_wre  in  1  GBUS write enable
g_dti  out  16  GBUS read data
g_ack  out  1  GBUS acknowledge
m_adr  out  16  memory address, registered
m_dto  out  16  memory write data, registered
m_stb  out  1  memory strobe, registered
m_wre  out  1  memory write enable, registered
m_dti  in  16  memory read data
m_ack  in  1  memory acknowledge
gnt  out  2  current grant: bit0 = FBUS, bit1 = GBUS; one-hot or zero
tmo  out  1  one-cycle pulse when the watchdog completes a cycle

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; m_adr, m_dto, m_stb, m_wre, gnt, tmo, and the watchdog counter all cleared to 0.
  - Last-served flag lst = GBUS, so the first tie goes to FBUS.
- States: IDLE, BUSF, BUSG.
- IDLE:
  - f_stb only: go to BUSF. g_stb only: go to BUSG.
  - Both requesting with RRB=1: grant the port that is not lst. With RRB=0: grant FBUS.
  - Neither requesting: stay in IDLE.
  - On a grant edge, m_adr, m_dto and m_wre are captured from the granted port, m_stb is set to 1, gnt is set, and lst is updated.
  - Latency: request sampled at edge n; m_stb is high after edge n.
  - m_ack arriving while in IDLE is ignored.
- BUSx (x = granted port):
  - m_adr, m_dto and m_wre are held stable.
  - x_ack = m_ack and x_dti = m_dti, both combinational passthrough.
  - The other port's ack is 0 and its dti is 16'h0000.
  - On m_ack: next state IDLE; m_stb, m_wre and gnt are cleared. Exactly one idle turnaround cycle follows every transfer, so the earliest next grant is at the edge after entering IDLE.
  - Abort: if x_stb is low while in BUSx and m_ack is low, go to IDLE with m_stb cleared. No ack is forwarded and tmo stays 0.
  - Watchdog (TMO>0): the counter clears on grant and increments each BUSx cycle without m_ack. In the cycle where the counter equals TMO-1 and m_ack is low:
    - x_ack = 1 and x_dti = 16'hFFFF, both combinational.
    - tmo = 1 for the following cycle (registered).
    - Next state IDLE.
  - m_ack and watchdog expiry in the same cycle: the real ack wins, with m_dti forwarded and tmo = 0.
- Outputs f_ack/g_ack are 0 in IDLE. gnt is never 2'b11.
- Writes use the same flow; x_dti is don't-care on writes but is still passed through.

Test Plan:
- Reset mid-transfer: BUSF active with m_stb=1, assert rst low asynchronously -> m_stb, gnt and tmo are 0 immediately; state is IDLE; the next f_stb is granted normally.
- Single FBUS read: f_stb=1, f_adr=16'h0100; memory acks 2 cycles after m_stb with m_dti=16'h7C01 -> m_adr=16'h0100, m_stb rises one edge after request; f_ack=1 with f_dti=16'h7C01 in the ack cycle; g_ack stays 0; gnt=01 then 00.
- Simultaneous requests, RRB=1: f_stb and g_stb held high, zero-wait memory -> grants alternate F, G, F, G with one idle cycle between each; with RRB=0 FBUS is always granted while f_stb is held.
- GBUS write: g_stb=1, g_wre=1, g_adr=16'h8000, g_dto=16'hBEEF -> m_wre=1, m_dto=16'hBEEF and m_adr=16'h8000 stable until m_ack; g_ack mirrors m_ack.
- Watchdog with TMO=4: FBUS request, m_ack never asserted -> f_ack=1 with f_dti=16'hFFFF in the 4th BUSF cycle; tmo=1 on the next cycle; state returns to IDLE. Repeating with m_ack arriving in the 4th cycle -> real data is returned and tmo=0.
- Abort: FBUS granted, f_stb dropped before m_ack -> m_stb=0 next edge, no f_ack, tmo=0, a pending g_stb is granted after the turnaround cycle.
